// File: rtl/red_centroid_tracker.sv
// Red-mask centroid tracker: accumulates mask-pixel count and coordinate sums per frame,
// then divides sums by count with two bit-serial restoring dividers to report the centroid.
module red_centroid_tracker #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter int MIN_PIXELS = 64
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [10:0] iX_Cont,
  input  logic [10:0] iY_Cont,
  input  logic [11:0] iRed,
  input  logic        iDVAL,
  output logic [10:0] oCent_X,
  output logic [10:0] oCent_Y,
  output logic [18:0] oCount,
  output logic        oFound,
  output logic        oValid,
  output logic        oDrop
);

  typedef enum logic [1:0] {ACCUM, DIV, DONE} state_t;

  state_t      state, stateNext;

  logic [18:0] cnt;
  logic [27:0] sumX, sumY;

  logic [18:0] snapCnt;
  logic        snapFound;
  logic [27:0] quotX, quotY;
  logic [19:0] remX, remY;
  logic [4:0]  stepCnt;

  logic        hit, frameEnd, found, loadSnap, dropNext;
  logic [18:0] cntInc;
  logic [27:0] sumXInc, sumYInc;
  logic [19:0] remShX, remShY, divisor;
  logic        geX, geY;

  assign hit = iDVAL && (iRed == 12'hFFF) &&
               (iX_Cont < 11'(WIDTH)) && (iY_Cont < 11'(HEIGHT));
  assign frameEnd = iDVAL && (iX_Cont == 11'(WIDTH - 1)) && (iY_Cont == 11'(HEIGHT - 1));

  // Frame totals including the current pixel, so the FE pixel lands in its own frame.
  assign cntInc  = cnt + 19'(hit);
  assign sumXInc = sumX + (hit ? 28'(iX_Cont) : 28'd0);
  assign sumYInc = sumY + (hit ? 28'(iY_Cont) : 28'd0);
  assign found   = (cntInc >= 19'(MIN_PIXELS));

  // One restoring step per cycle: dividend bits shift out of quot, quotient bits shift in.
  assign divisor = {1'b0, snapCnt};
  assign remShX  = {remX[18:0], quotX[27]};
  assign remShY  = {remY[18:0], quotY[27]};
  assign geX     = (remShX >= divisor);
  assign geY     = (remShY >= divisor);

  always_comb begin
    stateNext = state;
    loadSnap  = 1'b0;
    dropNext  = 1'b0;
    case (state)
      ACCUM: begin
        if (frameEnd) begin
          loadSnap  = 1'b1;
          stateNext = found ? DIV : DONE;
        end
      end
      DIV: begin
        dropNext = frameEnd;
        if (stepCnt == 5'd27) stateNext = DONE;
      end
      DONE: begin
        dropNext  = frameEnd;
        stateNext = ACCUM;
      end
      default: stateNext = ACCUM;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state <= ACCUM;
    end else begin
      state <= stateNext;
    end
  end

  // Accumulators keep running in every state; any FE (kept or dropped) starts a fresh frame.
  always_ff @(posedge iCLK) begin
    if (!iRST_N || frameEnd) begin
      cnt  <= '0;
      sumX <= '0;
      sumY <= '0;
    end else if (hit) begin
      cnt  <= cntInc;
      sumX <= sumXInc;
      sumY <= sumYInc;
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      snapCnt   <= '0;
      snapFound <= 1'b0;
      quotX     <= '0;
      quotY     <= '0;
      remX      <= '0;
      remY      <= '0;
      stepCnt   <= '0;
    end else if (loadSnap) begin
      snapCnt   <= cntInc;
      snapFound <= found;
      quotX     <= sumXInc;
      quotY     <= sumYInc;
      remX      <= '0;
      remY      <= '0;
      stepCnt   <= '0;
    end else if (state == DIV) begin
      remX    <= geX ? (remShX - divisor) : remShX;
      remY    <= geY ? (remShY - divisor) : remShY;
      quotX   <= {quotX[26:0], geX};
      quotY   <= {quotY[26:0], geY};
      stepCnt <= stepCnt + 5'd1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      oCent_X <= '0;
      oCent_Y <= '0;
      oCount  <= '0;
      oFound  <= 1'b0;
      oValid  <= 1'b0;
      oDrop   <= 1'b0;
    end else begin
      oValid <= 1'b0;
      oDrop  <= dropNext;
      if (state == DONE) begin
        oValid  <= 1'b1;
        oCount  <= snapCnt;
        oFound  <= snapFound;
        oCent_X <= snapFound ? quotX[10:0] : 11'd0;
        oCent_Y <= snapFound ? quotY[10:0] : 11'd0;
      end
    end
  end

endmodule

// File: tb/tb_red_centroid_tracker.sv
// Directed bench for red_centroid_tracker: full-size instance (MIN_PIXELS=1) and a
// tiny 8x6 instance (MIN_PIXELS=4) so a full-red frame fits in a short run.
module tb_red_centroid_tracker;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;

  logic [10:0] aX = '0, aY = '0;
  logic [11:0] aRed = '0;
  logic        aDval = 1'b0;
  logic [10:0] aCx, aCy;
  logic [18:0] aCount;
  logic        aFound, aValid, aDrop;

  logic [10:0] bX = '0, bY = '0;
  logic [11:0] bRed = '0;
  logic        bDval = 1'b0;
  logic [10:0] bCx, bCy;
  logic [18:0] bCount;
  logic        bFound, bValid, bDrop;

  int nCompared = 0;
  int nMismatched = 0;
  int lat;

  always #5 clk = ~clk;

  red_centroid_tracker #(.WIDTH(640), .HEIGHT(480), .MIN_PIXELS(1)) dutA (
    .iCLK(clk), .iRST_N(rstN), .iX_Cont(aX), .iY_Cont(aY), .iRed(aRed), .iDVAL(aDval),
    .oCent_X(aCx), .oCent_Y(aCy), .oCount(aCount), .oFound(aFound),
    .oValid(aValid), .oDrop(aDrop)
  );

  red_centroid_tracker #(.WIDTH(8), .HEIGHT(6), .MIN_PIXELS(4)) dutB (
    .iCLK(clk), .iRST_N(rstN), .iX_Cont(bX), .iY_Cont(bY), .iRed(bRed), .iDVAL(bDval),
    .oCent_X(bCx), .oCent_Y(bCy), .oCount(bCount), .oFound(bFound),
    .oValid(bValid), .oDrop(bDrop)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    nCompared++;
    if (obs !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Present one pixel for one sampling edge, then return just after that edge.
  task automatic pix(input int sel, input int x, input int y, input bit red, input bit dval);
    @(negedge clk);
    if (sel == 0) begin
      aX = 11'(x); aY = 11'(y); aRed = red ? 12'hFFF : 12'h000; aDval = dval;
    end else begin
      bX = 11'(x); bY = 11'(y); bRed = red ? 12'hFFF : 12'h000; bDval = dval;
    end
    @(posedge clk);
    #1;
    aDval = 1'b0;
    bDval = 1'b0;
  endtask

  // Edges after the last one until oValid is seen high; -1 if it never appears.
  task automatic waitValid(input int sel, output int latency);
    latency = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if ((sel == 0) ? aValid : bValid) begin
        latency = n;
        break;
      end
    end
  endtask

  task automatic checkA(input string tag, input int cx, input int cy, input int count, input int fnd);
    chk({tag, "_cx"}, int'(aCx), cx);
    chk({tag, "_cy"}, int'(aCy), cy);
    chk({tag, "_count"}, int'(aCount), count);
    chk({tag, "_found"}, int'(aFound), fnd);
    $display("txn %s: cent=(%0d,%0d) count=%0d found=%0d", tag, aCx, aCy, aCount, aFound);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(aValid), 0);
    chk("rst_count", int'(aCount), 0);
    chk("rst_drop", int'(aDrop), 0);
    chk("rst_b_valid", int'(bValid), 0);
    @(negedge clk);
    rstN = 1'b1;

    // Single hit; FE pixel itself is not red.
    pix(0, 100, 50, 1, 1);
    pix(0, 639, 479, 0, 1);
    waitValid(0, lat);
    chk("single_lat", lat, 29);
    checkA("single", 100, 50, 1, 1);
    @(posedge clk); #1;
    chk("single_pulse", int'(aValid), 0);

    // 4x4 block.
    for (int y = 300; y < 304; y++)
      for (int x = 200; x < 204; x++)
        pix(0, x, y, 1, 1);
    pix(0, 639, 479, 0, 1);
    waitValid(0, lat);
    chk("block_lat", lat, 29);
    checkA("block", 201, 301, 16, 1);

    // Ignored pixels and a non-FE (639,479) with iDVAL=0.
    pix(0, 300, 200, 1, 0);
    pix(0, 700, 10, 1, 1);
    pix(0, 639, 479, 1, 0);
    waitValid(0, lat);
    chk("nofe_lat", lat, -1);
    pix(0, 639, 479, 0, 1);
    waitValid(0, lat);
    chk("black_lat", lat, 1);
    checkA("black", 0, 0, 0, 0);

    // Overrun: second FE ten edges after the first.
    pix(0, 100, 50, 1, 1);
    pix(0, 639, 479, 0, 1);
    repeat (9) @(posedge clk);
    pix(0, 639, 479, 1, 1);
    chk("ovr_drop", int'(aDrop), 1);
    waitValid(0, lat);
    chk("ovr_lat", lat, 19);
    checkA("ovr", 100, 50, 1, 1);
    chk("ovr_drop_end", int'(aDrop), 0);
    pix(0, 3, 3, 1, 1);
    pix(0, 639, 479, 0, 1);
    waitValid(0, lat);
    checkA("after_ovr", 3, 3, 1, 1);

    // Reset in the middle of a divide.
    pix(0, 5, 7, 1, 1);
    pix(0, 639, 479, 0, 1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rstN = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", int'(aValid), 0);
    chk("midrst_count", int'(aCount), 0);
    chk("midrst_cx", int'(aCx), 0);
    chk("midrst_found", int'(aFound), 0);
    @(negedge clk);
    rstN = 1'b1;
    waitValid(0, lat);
    chk("aborted_lat", lat, -1);
    for (int f = 0; f < 2; f++) begin
      pix(0, 5, 7, 1, 1);
      pix(0, 639, 479, 0, 1);
      waitValid(0, lat);
      chk("post_rst_lat", lat, 29);
      checkA("post_rst", 5, 7, 1, 1);
    end

    // Small instance: full-red 8x6 frame -> sums 168 and 120 over 48 pixels.
    for (int y = 0; y < 6; y++)
      for (int x = 0; x < 8; x++)
        pix(1, x, y, 1, 1);
    waitValid(1, lat);
    chk("full_lat", lat, 29);
    chk("full_cx", int'(bCx), 3);
    chk("full_cy", int'(bCy), 2);
    chk("full_count", int'(bCount), 48);
    chk("full_found", int'(bFound), 1);
    $display("txn full: cent=(%0d,%0d) count=%0d found=%0d", bCx, bCy, bCount, bFound);

    // Below threshold: 3 hits against MIN_PIXELS=4.
    pix(1, 1, 1, 1, 1);
    pix(1, 2, 1, 1, 1);
    pix(1, 3, 1, 1, 1);
    pix(1, 7, 5, 0, 1);
    waitValid(1, lat);
    chk("thr_lat", lat, 1);
    chk("thr_cx", int'(bCx), 0);
    chk("thr_cy", int'(bCy), 0);
    chk("thr_count", int'(bCount), 3);
    chk("thr_found", int'(bFound), 0);
    $display("txn thr: cent=(%0d,%0d) count=%0d found=%0d", bCx, bCy, bCount, bFound);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
